dma_request_arbiter: RTL and testbench

DMA_REQUEST_ARBITER -- requirements
Module: dma_request_arbiter

---
 rtl/dma_request_arbiter.sv | 168 ++++++++++++++++
 tb/tb_dma_request_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/dma_request_arbiter.sv
// Two-channel DMA request arbiter: negotiates the processor bus via HREQ/HACK,
// grants one IO device at a time and tracks the programmed word count.
// Define DMA_ROUND_ROBIN_EN to replace fixed ch1 priority with round-robin.
module dma_request_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             DREQ1,
    input  logic             DREQ2,
    input  logic             HACK,
    input  logic             xfer_done,
    input  logic             cnt_load,
    input  logic [CNT_W-1:0] cnt_in,
    output logic             HREQ,
    output logic             DACK1,
    output logic             DACK2,
    output logic             chan,
    output logic [CNT_W-1:0] word_count,
    output logic             busy,
    output logic             tc
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD_REQ = 2'd1,
        GRANT    = 2'd2,
        RELEASE  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic             chan_q, chan_d;
    logic [CNT_W-1:0] wc_q, wc_d;
    logic             hreq_q, hreq_d;
    logic             dack1_q, dack1_d;
    logic             dack2_q, dack2_d;
    logic             busy_q, busy_d;
    logic             tc_q, tc_d;

    logic             chosen_req;
    logic             wc_zero;
    logic             wc_one;
    logic             pick;

`ifdef DMA_ROUND_ROBIN_EN
    // Last channel that reached GRANT: 0 = ch1, 1 = ch2.
    logic last_q, last_d;
`endif

    assign chosen_req = chan_q ? DREQ2 : DREQ1;
    assign wc_zero    = (wc_q == '0);
    assign wc_one     = (wc_q == CNT_W'(1));

    // Channel selected when leaving IDLE.
`ifdef DMA_ROUND_ROBIN_EN
    assign pick = (DREQ1 && DREQ2) ? ~last_q : ~DREQ1;
`else
    assign pick = ~DREQ1;
`endif

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        chan_d  = chan_q;
        wc_d    = wc_q;
        tc_d    = 1'b0;
`ifdef DMA_ROUND_ROBIN_EN
        last_d  = last_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (cnt_load) begin
                    wc_d = cnt_in;
                end
                if (!wc_zero && (DREQ1 || DREQ2)) begin
                    state_d = HOLD_REQ;
                    chan_d  = pick;
                end
            end

            HOLD_REQ: begin
                if (!chosen_req) begin
                    state_d = RELEASE;
                end else if (HACK) begin
                    state_d = GRANT;
`ifdef DMA_ROUND_ROBIN_EN
                    last_d  = chan_q;
`endif
                end
            end

            GRANT: begin
                // A revoked bus wins over everything else; the count is preserved.
                if (!HACK) begin
                    state_d = IDLE;
                end else if (xfer_done && !wc_zero) begin
                    wc_d = wc_q - CNT_W'(1);
                    if (wc_one) begin
                        tc_d    = 1'b1;
                        state_d = RELEASE;
                    end else if (!chosen_req) begin
                        state_d = RELEASE;
                    end
                end else if (!chosen_req) begin
                    state_d = RELEASE;
                end
            end

            RELEASE: begin
                if (!HACK) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with the state edge.
        hreq_d  = (state_d == HOLD_REQ) || (state_d == GRANT);
        dack1_d = (state_d == GRANT) && !chan_d;
        dack2_d = (state_d == GRANT) &&  chan_d;
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (reset) begin
            state_q <= IDLE;
            chan_q  <= 1'b0;
            wc_q    <= '0;
            hreq_q  <= 1'b0;
            dack1_q <= 1'b0;
            dack2_q <= 1'b0;
            busy_q  <= 1'b0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            wc_q    <= wc_d;
            hreq_q  <= hreq_d;
            dack1_q <= dack1_d;
            dack2_q <= dack2_d;
            busy_q  <= busy_d;
            tc_q    <= tc_d;
        end
    end

`ifdef DMA_ROUND_ROBIN_EN
    // Reset points at ch2 so ch1 wins the first contested arbitration.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign HREQ       = hreq_q;
    assign DACK1      = dack1_q;
    assign DACK2      = dack2_q;
    assign chan       = chan_q;
    assign word_count = wc_q;
    assign busy       = busy_q;
    assign tc         = tc_q;

endmodule

// File: tb/tb_dma_request_arbiter.sv
// Directed bench for dma_request_arbiter: expected output snapshots are queued
// as each step is driven and compared one cycle later against the DUT outputs.
module tb_dma_request_arbiter;

    localparam int CNT_W = 8;

`ifdef DMA_ROUND_ROBIN_EN
    localparam logic SECOND_CH = 1'b1;
`else
    localparam logic SECOND_CH = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             DREQ1, DREQ2, HACK, xfer_done, cnt_load;
    logic [CNT_W-1:0] cnt_in;
    logic             HREQ, DACK1, DACK2, chan, busy, tc;
    logic [CNT_W-1:0] word_count;

    // Snapshot order: {HREQ, DACK1, DACK2, chan, busy, tc, word_count}
    typedef struct {
        string           tag;
        logic [CNT_W+5:0] v;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    dma_request_arbiter #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .DREQ1      (DREQ1),
        .DREQ2      (DREQ2),
        .HACK       (HACK),
        .xfer_done  (xfer_done),
        .cnt_load   (cnt_load),
        .cnt_in     (cnt_in),
        .HREQ       (HREQ),
        .DACK1      (DACK1),
        .DACK2      (DACK2),
        .chan       (chan),
        .word_count (word_count),
        .busy       (busy),
        .tc         (tc)
    );

    always #5 clk = ~clk;

    // Queue the expectation for the inputs currently driven, clock once, then compare.
    task automatic step(input string tag, input logic hreq, input logic d1, input logic d2,
                        input logic ch, input logic bsy, input logic t, input logic [CNT_W-1:0] wc);
        exp_t e;
        exp_t got;
        logic [CNT_W+5:0] obs;
        e.tag = tag;
        e.v   = {hreq, d1, d2, ch, bsy, t, wc};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        obs = {HREQ, DACK1, DACK2, chan, busy, tc, word_count};
        checks++;
        assert (obs === got.v) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b (HREQ,DACK1,DACK2,chan,busy,tc,wc)",
                   got.tag, obs, got.v);
        end
    endtask

    initial begin
        reset = 1'b1; DREQ1 = 1'b0; DREQ2 = 1'b0; HACK = 1'b0;
        xfer_done = 1'b0; cnt_load = 1'b0; cnt_in = '0;
        step("reset", 0, 0, 0, 0, 0, 0, 8'd0);
        reset = 1'b0;

        // Three-word transfer on ch1 ending in terminal count
        cnt_load = 1'b1; cnt_in = 8'd3;
        step("load3", 0, 0, 0, 0, 0, 0, 8'd3);
        cnt_load = 1'b0; DREQ1 = 1'b1;
        step("a_hreq", 1, 0, 0, 0, 1, 0, 8'd3);
        HACK = 1'b1;
        step("a_dack1", 1, 1, 0, 0, 1, 0, 8'd3);
        xfer_done = 1'b1;
        step("a_wc2", 1, 1, 0, 0, 1, 0, 8'd2);
        step("a_wc1", 1, 1, 0, 0, 1, 0, 8'd1);
        step("a_tc", 0, 0, 0, 0, 1, 1, 8'd0);
        xfer_done = 1'b0; HACK = 1'b0; DREQ1 = 1'b0;
        step("a_idle", 0, 0, 0, 0, 0, 0, 8'd0);

        // Requests ignored while the count is zero
        reset = 1'b1;
        step("reset2", 0, 0, 0, 0, 0, 0, 8'd0);
        reset = 1'b0; DREQ2 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step("b_zero_cnt", 0, 0, 0, 0, 0, 0, 8'd0);
        end
        DREQ2 = 1'b0;

        // Two contested single-word sessions: priority vs round-robin
        cnt_load = 1'b1; cnt_in = 8'd5;
        step("c_load5", 0, 0, 0, 0, 0, 0, 8'd5);
        cnt_load = 1'b0; DREQ1 = 1'b1; DREQ2 = 1'b1;
        step("c_hold1", 1, 0, 0, 0, 1, 0, 8'd5);
        HACK = 1'b1;
        step("c_grant1", 1, 1, 0, 0, 1, 0, 8'd5);
        xfer_done = 1'b1; DREQ1 = 1'b0;
        step("c_rel1", 0, 0, 0, 0, 1, 0, 8'd4);
        xfer_done = 1'b0; HACK = 1'b0; DREQ1 = 1'b1;
        step("c_idle1", 0, 0, 0, 0, 0, 0, 8'd4);
        step("c_hold2", 1, 0, 0, SECOND_CH, 1, 0, 8'd4);
        HACK = 1'b1;
        step("c_grant2", 1, !SECOND_CH, SECOND_CH, SECOND_CH, 1, 0, 8'd4);
        xfer_done = 1'b1;
        if (SECOND_CH) DREQ2 = 1'b0; else DREQ1 = 1'b0;
        step("c_rel2", 0, 0, 0, SECOND_CH, 1, 0, 8'd3);
        xfer_done = 1'b0; HACK = 1'b0; DREQ1 = 1'b0; DREQ2 = 1'b0;
        step("c_idle2", 0, 0, 0, SECOND_CH, 0, 0, 8'd3);

        // DREQ2 drop coinciding with xfer_done counts the word, then releases
        cnt_load = 1'b1; cnt_in = 8'd2;
        step("d_load2", 0, 0, 0, SECOND_CH, 0, 0, 8'd2);
        cnt_load = 1'b0; DREQ2 = 1'b1;
        step("d_hold", 1, 0, 0, 1, 1, 0, 8'd2);
        HACK = 1'b1;
        step("d_dack2", 1, 0, 1, 1, 1, 0, 8'd2);
        xfer_done = 1'b1; DREQ2 = 1'b0;
        step("d_rel", 0, 0, 0, 1, 1, 0, 8'd1);
        xfer_done = 1'b0; HACK = 1'b0;
        step("d_idle", 0, 0, 0, 1, 0, 0, 8'd1);

        // Processor revoke in GRANT, load ignored in GRANT, reset mid-GRANT
        cnt_load = 1'b1; cnt_in = 8'd4;
        step("e_load4", 0, 0, 0, 1, 0, 0, 8'd4);
        cnt_load = 1'b0; DREQ1 = 1'b1;
        step("e_hold", 1, 0, 0, 0, 1, 0, 8'd4);
        HACK = 1'b1;
        step("e_grant", 1, 1, 0, 0, 1, 0, 8'd4);
        cnt_load = 1'b1; cnt_in = 8'd9;
        step("e_load_ignored", 1, 1, 0, 0, 1, 0, 8'd4);
        cnt_load = 1'b0; HACK = 1'b0;
        step("e_revoke", 0, 0, 0, 0, 0, 0, 8'd4);
        step("e_rehold", 1, 0, 0, 0, 1, 0, 8'd4);
        step("e_wait_hack", 1, 0, 0, 0, 1, 0, 8'd4);
        HACK = 1'b1;
        step("e_regrant", 1, 1, 0, 0, 1, 0, 8'd4);
        reset = 1'b1; xfer_done = 1'b1; cnt_load = 1'b1; cnt_in = 8'd1;
        step("e_reset_grant", 0, 0, 0, 0, 0, 0, 8'd0);
        reset = 1'b0; xfer_done = 1'b0; cnt_load = 1'b0; HACK = 1'b0; DREQ1 = 1'b0;
        step("e_after_reset", 0, 0, 0, 0, 0, 0, 8'd0);

        // Stray xfer_done in IDLE, drop before HACK, drop in GRANT without a word
        cnt_load = 1'b1; cnt_in = 8'd2;
        step("f_load2", 0, 0, 0, 0, 0, 0, 8'd2);
        cnt_load = 1'b0; xfer_done = 1'b1;
        step("f_stray_xfer", 0, 0, 0, 0, 0, 0, 8'd2);
        xfer_done = 1'b0; DREQ2 = 1'b1;
        step("f_hold", 1, 0, 0, 1, 1, 0, 8'd2);
        DREQ2 = 1'b0; cnt_load = 1'b1; cnt_in = 8'd7;
        step("f_early_drop", 0, 0, 0, 1, 1, 0, 8'd2);
        cnt_load = 1'b0;
        step("f_idle", 0, 0, 0, 1, 0, 0, 8'd2);
        DREQ1 = 1'b1;
        step("f_hold1", 1, 0, 0, 0, 1, 0, 8'd2);
        HACK = 1'b1;
        step("f_grant1", 1, 1, 0, 0, 1, 0, 8'd2);
        DREQ1 = 1'b0;
        step("f_drop_no_xfer", 0, 0, 0, 0, 1, 0, 8'd2);
        step("f_release_hold", 0, 0, 0, 0, 1, 0, 8'd2);
        HACK = 1'b0;
        step("f_idle_end", 0, 0, 0, 0, 0, 0, 8'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
